// File: rtl/conv_pool2d.sv
// conv_pool2d: optional ReLU then 2x2 stride-2 max pooling of a raster feature map.
// Ports: clk, reset (sync, active-high), fin_start/din_vld/din in; fout_start/dout_vld/dout/frame_abort out.
module conv_pool2d #(
  parameter int DATA_WIDTH = 8,
  parameter int FMAP_W     = 8,
  parameter int FMAP_H     = 8,
  parameter int RELU_EN    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fin_start,
  input  logic                         din_vld,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic                         fout_start,
  output logic                         dout_vld,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         frame_abort
);

  localparam int CW = $clog2(FMAP_W);
  localparam int RW = $clog2(FMAP_H);
  localparam int LN = FMAP_W / 2;
  localparam int LW = (LN > 1) ? $clog2(LN) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(FMAP_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_H - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state;
  logic [CW-1:0] col;
  logic [CW-1:0] pc;
  logic [RW-1:0] row;
  logic [RW-1:0] pr;
  logic          acc;
  logic          start;
  logic [LW-1:0] li;

  logic signed [DATA_WIDTH-1:0] s;
  logic signed [DATA_WIDTH-1:0] held;
  logic signed [DATA_WIDTH-1:0] hmax;
  logic signed [DATA_WIDTH-1:0] lval;
  logic signed [DATA_WIDTH-1:0] vmax;
  logic signed [DATA_WIDTH-1:0] lbuf [LN];

  // A start sample is always pixel (0,0), whatever
  // the counters currently say.
  always_comb begin
    acc   = din_vld && (state == ACTIVE || fin_start);
    start = acc && fin_start;
    pc    = start ? '0 : col;
    pr    = start ? '0 : row;
    s     = (RELU_EN != 0 && din[DATA_WIDTH-1]) ? '0 : din;
    hmax  = (held > s) ? held : s;
    li    = LW'(pc >> 1);
    lval  = lbuf[li];
    vmax  = (lval > hmax) ? lval : hmax;
  end

  // Held sample and line buffer are always written
  // before being read within a frame, so no reset.
  always_ff @(posedge clk) begin
    if (acc && !reset) begin
      if (!pc[0])
        held <= s;
      else if (!pr[0])
        lbuf[li] <= hmax;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      dout        <= '0;
      dout_vld    <= 1'b0;
      fout_start  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      dout_vld    <= 1'b0;
      fout_start  <= 1'b0;
      frame_abort <= 1'b0;
      if (acc) begin
        frame_abort <= start && state == ACTIVE &&
                       (col != '0 || row != '0);
        if (pc[0] && pr[0]) begin
          dout       <= vmax;
          dout_vld   <= 1'b1;
          fout_start <= (pr == RW'(1)) && (pc == CW'(1));
        end
        unique case (1'b1)
          (pc != COL_LAST): begin
            col   <= pc + 1'b1;
            row   <= pr;
            state <= ACTIVE;
          end
          (pc == COL_LAST && pr != ROW_LAST): begin
            col   <= '0;
            row   <= pr + 1'b1;
            state <= ACTIVE;
          end
          default: begin
            col   <= '0;
            row   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
